// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with multi-cycle MUL/DIV/REM and valid/ready handshake
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic [3:0]       opcode,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             div_zero
);
    localparam int W2 = 2 * WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRL = 4'h5;
    localparam logic [3:0] OP_SRA = 4'h6;
    localparam logic [3:0] OP_GT  = 4'h7;
    localparam logic [3:0] OP_LT  = 4'h8;
    localparam logic [3:0] OP_MUL = 4'h9;
    localparam logic [3:0] OP_DIV = 4'hA;
    localparam logic [3:0] OP_REM = 4'hB;

    logic [1:0]       r_state;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_overflow;
    logic             r_div_zero;

    logic [3:0]       r_op;
    logic             r_mode;
    logic             r_neg_a;
    logic             r_neg_b;
    logic             r_b_zero;
    logic             r_div_ovf;
    logic [WIDTH-1:0] r_a;
    logic [W2-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [W2-1:0]    r_prod;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;

    logic             w_accept;
    logic             w_busy;
    logic             w_last;
    logic             w_multi;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_gt;
    logic             w_lt;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_ovf;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [W2-1:0]    w_prod_nx;
    logic [W2-1:0]    w_prod_s;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_quo_s;
    logic [WIDTH-1:0] w_rem_s;
    logic [WIDTH-1:0] w_mc_res;
    logic             w_mc_ovf;
    logic             w_mc_dz;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign div_zero  = r_div_zero;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_busy   = (r_state == BUSY);
    assign w_last   = (r_cnt == SHW'(WIDTH - 1));
    assign w_multi  = (opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_REM);

    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} - {1'b0, b};
    assign w_gt  = mode ? ($signed(a) > $signed(b)) : (a > b);
    assign w_lt  = mode ? ($signed(a) < $signed(b)) : (a < b);

    always_comb begin
        w_sc_res = '0;
        w_sc_ovf = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_sc_res = w_add[WIDTH-1:0];
                w_sc_ovf = mode ? ((a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]))
                                : w_add[WIDTH];
            end
            OP_SUB: begin
                w_sc_res = w_sub[WIDTH-1:0];
                w_sc_ovf = mode ? ((a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]))
                                : w_sub[WIDTH];
            end
            OP_AND: w_sc_res = a & b;
            OP_OR:  w_sc_res = a | b;
            OP_SLL: w_sc_res = a << shamt;
            OP_SRL: w_sc_res = a >> shamt;
            OP_SRA: w_sc_res = $unsigned($signed(a) >>> shamt);
            OP_GT:  w_sc_res = {{(WIDTH-1){1'b0}}, w_gt};
            OP_LT:  w_sc_res = {{(WIDTH-1){1'b0}}, w_lt};
            default: ;
        endcase
    end

    // Iterative units run on magnitudes; signs are restored on the final edge.
    assign w_neg_a = mode && a[WIDTH-1];
    assign w_neg_b = mode && b[WIDTH-1];
    assign w_mag_a = w_neg_a ? ((~a) + WIDTH'(1)) : a;
    assign w_mag_b = w_neg_b ? ((~b) + WIDTH'(1)) : b;

    assign w_prod_nx = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_prod_s  = (r_neg_a ^ r_neg_b) ? ((~w_prod_nx) + W2'(1)) : w_prod_nx;

    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_divisor};
    assign w_ge     = ~w_diff[WIDTH];
    assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
    assign w_quo_s  = (r_neg_a ^ r_neg_b) ? ((~w_quo_nx) + WIDTH'(1)) : w_quo_nx;
    assign w_rem_s  = r_neg_a ? ((~w_rem_nx) + WIDTH'(1)) : w_rem_nx;

    always_comb begin
        w_mc_res = '0;
        w_mc_ovf = 1'b0;
        w_mc_dz  = 1'b0;
        case (r_op)
            OP_MUL: begin
                w_mc_res = w_prod_s[WIDTH-1:0];
                w_mc_ovf = r_mode ? (w_prod_s[W2-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}})
                                  : (|w_prod_s[W2-1:WIDTH]);
            end
            OP_DIV: begin
                w_mc_res = r_b_zero ? '1 : w_quo_s;
                w_mc_ovf = r_div_ovf;
                w_mc_dz  = r_b_zero;
            end
            OP_REM: begin
                w_mc_res = r_b_zero ? r_a : w_rem_s;
                w_mc_ovf = r_div_ovf;
                w_mc_dz  = r_b_zero;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_multi) begin
                            r_state <= BUSY;
                            r_cnt   <= '0;
                        end else begin
                            r_state    <= DONE;
                            r_result   <= w_sc_res;
                            r_overflow <= w_sc_ovf;
                            r_div_zero <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + SHW'(1);
                    if (w_last) begin
                        r_state    <= DONE;
                        r_result   <= w_mc_res;
                        r_overflow <= w_mc_ovf;
                        r_div_zero <= w_mc_dz;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op      <= opcode;
            r_mode    <= mode;
            r_neg_a   <= w_neg_a;
            r_neg_b   <= w_neg_b;
            r_a       <= a;
            r_b_zero  <= (b == '0);
            r_div_ovf <= mode && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
            r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier  <= w_mag_b;
            r_prod    <= '0;
            r_divisor <= w_mag_b;
            r_quo     <= w_mag_a;
            r_rem     <= '0;
        end else if (w_busy) begin
            r_prod   <= w_prod_nx;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_quo    <= w_quo_nx;
            r_rem    <= w_rem_nx;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
    logic [3:0]  opcode;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        div_zero;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        dz;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .opcode    (opcode),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit fits(input longint v, input logic md);
        if (md) return (v >= -longint'(32'h8000_0000)) && (v <= longint'(32'h7FFF_FFFF));
        return (v >= 0) && (v <= longint'(32'hFFFF_FFFF));
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic md, input logic [31:0] x,
                                   input logic [31:0] y, input logic [4:0] sh);
        exp_t        e;
        longint      sx;
        longint      sy;
        longint      full;
        logic [63:0] up;
        e.res = '0;
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        e.lat = (op == 4'h9 || op == 4'hA || op == 4'hB) ? 33 : 1;
        e.tag = "";
        sx = md ? longint'($signed(x)) : longint'({32'h0, x});
        sy = md ? longint'($signed(y)) : longint'({32'h0, y});
        case (op)
            4'h0: begin full = sx + sy; e.res = full[31:0]; e.ovf = !fits(full, md); end
            4'h1: begin full = sx - sy; e.res = full[31:0]; e.ovf = !fits(full, md); end
            4'h2: e.res = x & y;
            4'h3: e.res = x | y;
            4'h4: e.res = x << sh;
            4'h5: e.res = x >> sh;
            4'h6: e.res = $unsigned($signed(x) >>> sh);
            4'h7: e.res = {31'h0, sx > sy};
            4'h8: e.res = {31'h0, sx < sy};
            4'h9: begin
                if (md) begin
                    full = sx * sy; e.res = full[31:0]; e.ovf = !fits(full, md);
                end else begin
                    up = {32'h0, x} * {32'h0, y}; e.res = up[31:0]; e.ovf = |up[63:32];
                end
            end
            4'hA, 4'hB: begin
                if (y == 32'h0) begin
                    e.res = (op == 4'hA) ? 32'hFFFF_FFFF : x;
                    e.dz  = 1'b1;
                end else if (md && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.res = (op == 4'hA) ? 32'h8000_0000 : 32'h0;
                    e.ovf = 1'b1;
                end else begin
                    full  = (op == 4'hA) ? (sx / sy) : (sx % sy);
                    e.res = full[31:0];
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic scramble();
        a      = $urandom;
        b      = $urandom;
        mode   = 1'($urandom);
        opcode = 4'($urandom);
        shamt  = 5'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic md,
                          input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh,
                          input int hold);
        exp_t e;
        exp_t g;
        int   lat;
        e = model(op, md, x, y, sh);
        e.tag = tag;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(in_ready), 64'(1));
        opcode = op; mode = md; a = x; b = y; shamt = sh; in_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        g = sb.pop_front();
        check({g.tag, " latency"}, 64'(lat), 64'(g.lat));
        check({g.tag, " result"}, 64'(result), 64'(g.res));
        check({g.tag, " overflow"}, 64'(overflow), 64'(g.ovf));
        check({g.tag, " div_zero"}, 64'(div_zero), 64'(g.dz));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({g.tag, " hold result"}, 64'(result), 64'(g.res));
            check({g.tag, " hold in_ready"}, 64'(in_ready), 64'(0));
            check({g.tag, " hold out_valid"}, 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({g.tag, " release"}, 64'({in_ready, out_valid}), 64'(2'b10));
    endtask

    task automatic reset_mid_mul();
        bit seen;
        exp_t e;
        e = model(4'h9, 1'b1, 32'h0001_2345, 32'h0000_0777, 5'd0);
        @(negedge clk);
        opcode = 4'h9; mode = 1'b1; a = 32'h0001_2345; b = 32'h0000_0777; in_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("rst in_ready", 64'(in_ready), 64'(1));
        check("rst out_valid", 64'(out_valid), 64'(0));
        check("rst result", 64'(result), 64'(0));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rst no pulse", 64'(seen), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0]  rop;
        logic [31:0] ry;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; mode = 1'b0; opcode = '0; shamt = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'(1));
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset result", 64'(result), 64'(0));
        check("reset flags", 64'({overflow, div_zero}), 64'(0));
        rst = 1'b0;

        run_op("add_u_carry", 4'h0, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd0, 5);
        run_op("add_s_ovf",   4'h0, 1'b1, 32'h7FFF_FFFF, 32'h1, 5'd0, 0);
        run_op("sub_u_borrow",4'h1, 1'b0, 32'd3, 32'd5, 5'd0, 0);
        run_op("sub_s",       4'h1, 1'b1, 32'h8000_0000, 32'h1, 5'd0, 0);
        run_op("and",         4'h2, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 0);
        run_op("or",          4'h3, 1'b0, 32'hF000_0001, 32'h0000_1230, 5'd0, 0);
        run_op("sll",         4'h4, 1'b0, 32'h8000_0003, 32'h0, 5'd31, 0);
        run_op("srl",         4'h5, 1'b0, 32'h8000_0000, 32'h0, 5'd4, 0);
        run_op("sra",         4'h6, 1'b1, 32'h8000_0000, 32'h0, 5'd4, 0);
        run_op("lt_s",        4'h8, 1'b1, 32'hFFFF_FFFF, 32'h1, 5'd0, 0);
        run_op("op_f",        4'hF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
        run_op("mul_s",       4'h9, 1'b1, 32'hFFFF_FFFD, 32'd7, 5'd0, 0);
        run_op("mul_u_ovf",   4'h9, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd0, 0);
        run_op("div_s",       4'hA, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd0, 0);
        run_op("rem_s",       4'hB, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd0, 0);
        run_op("div_zero",    4'hA, 1'b0, 32'h0000_1234, 32'h0, 5'd0, 0);
        run_op("rem_zero",    4'hB, 1'b0, 32'h0000_1234, 32'h0, 5'd0, 0);
        run_op("div_min",     4'hA, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);
        run_op("rem_min",     4'hB, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);
        reset_mid_mul();
        run_op("gt_u",        4'h7, 1'b0, 32'h1, 32'hFFFF_FFFF, 5'd0, 0);
        run_op("gt_s",        4'h7, 1'b1, 32'h1, 32'hFFFF_FFFF, 5'd0, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ry  = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom);
            run_op("rnd", rop, 1'($urandom), 32'($urandom), ry, 5'($urandom), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
